// File: rtl/sync_filter_bank_if.sv
// Bus bundle for sync_filter_bank: raw inputs, enable, threshold port,
// event clears and the filtered outputs.
interface sync_filter_bank_if #(
  parameter int NUM_CH    = 4,
  parameter int CTR_WIDTH = 4
);
  logic [NUM_CH-1:0]    async_i;
  logic                 en_i;
  logic                 thr_wr_i;
  logic [CTR_WIDTH-1:0] thr_high_i;
  logic [CTR_WIDTH-1:0] thr_low_i;
  logic                 cfg_err_o;
  logic [NUM_CH-1:0]    clr_i;
  logic [NUM_CH-1:0]    clean_out_o;
  logic [NUM_CH-1:0]    rise_o;
  logic [NUM_CH-1:0]    fall_o;
  logic [NUM_CH-1:0]    evt_o;

  modport master (
    output async_i,
    output en_i,
    output thr_wr_i,
    output thr_high_i,
    output thr_low_i,
    output clr_i,
    input  cfg_err_o,
    input  clean_out_o,
    input  rise_o,
    input  fall_o,
    input  evt_o
  );

  modport slave (
    input  async_i,
    input  en_i,
    input  thr_wr_i,
    input  thr_high_i,
    input  thr_low_i,
    input  clr_i,
    output cfg_err_o,
    output clean_out_o,
    output rise_o,
    output fall_o,
    output evt_o
  );
endinterface

// File: rtl/sync_filter_bank.sv
// Multi-channel synchronizer plus hysteresis counter filter with
// edge pulses, sticky W1C events and programmable thresholds.
module sync_filter_bank #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CTR_WIDTH   = 4,
  parameter int HIGH_THRESH = 12,
  parameter int LOW_THRESH  = 3
) (
  input logic clk_i,
  input logic rst_n_i,
  sync_filter_bank_if.slave bus
);

  localparam int CTR_MAX = (1 << CTR_WIDTH) - 1;

  typedef logic [CTR_WIDTH-1:0] ctr_t;

  localparam ctr_t HIGH_RST = ctr_t'(HIGH_THRESH);
  localparam ctr_t LOW_RST  = ctr_t'(LOW_THRESH);
  localparam ctr_t CTR_TOP  = ctr_t'(CTR_MAX);

  if (HIGH_THRESH <= LOW_THRESH) begin : g_bad_order
    $fatal(1, "sync_filter_bank: HIGH_THRESH must exceed LOW_THRESH");
  end
  if (HIGH_THRESH > CTR_MAX) begin : g_bad_high
    $fatal(1, "sync_filter_bank: HIGH_THRESH exceeds counter range");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $fatal(1, "sync_filter_bank: SYNC_STAGES must be 2..4");
  end

  logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
  ctr_t                   ctr_q  [NUM_CH];
  ctr_t                   ctr_d  [NUM_CH];

  logic [NUM_CH-1:0] sync_last;
  logic [NUM_CH-1:0] level_q;
  logic [NUM_CH-1:0] level_d;
  logic [NUM_CH-1:0] rise_q;
  logic [NUM_CH-1:0] fall_q;
  logic [NUM_CH-1:0] evt_q;

  ctr_t thr_high_q;
  ctr_t thr_low_q;
  logic cfg_err_q;
  logic thr_ok;

  assign thr_ok = bus.thr_high_i > bus.thr_low_i;

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sync_last[ch] = sync_q[ch][SYNC_STAGES-1];
      ctr_d[ch]     = ctr_q[ch];
      level_d[ch]   = level_q[ch];
      if (bus.en_i) begin
        if (sync_last[ch] && ctr_q[ch] != CTR_TOP) begin
          ctr_d[ch] = ctr_q[ch] + ctr_t'(1);
        end else if (!sync_last[ch] && ctr_q[ch] != '0) begin
          ctr_d[ch] = ctr_q[ch] - ctr_t'(1);
        end
        // Level decision looks at the current count, not the next one
        if (ctr_q[ch] >= thr_high_q) begin
          level_d[ch] = 1'b1;
        end else if (ctr_q[ch] <= thr_low_q) begin
          level_d[ch] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        sync_q[ch] <= '0;
        ctr_q[ch]  <= '0;
      end
      level_q    <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      evt_q      <= '0;
      cfg_err_q  <= 1'b0;
      thr_high_q <= HIGH_RST;
      thr_low_q  <= LOW_RST;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (bus.en_i) begin
          sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], bus.async_i[ch]};
        end
        ctr_q[ch] <= ctr_d[ch];
      end
      level_q   <= level_d;
      rise_q    <= {NUM_CH{bus.en_i}} & level_d & ~level_q;
      fall_q    <= {NUM_CH{bus.en_i}} & ~level_d & level_q;
      // Set from the visible pulse so a same-cycle clear loses
      evt_q     <= (evt_q & ~bus.clr_i) | rise_q | fall_q;
      cfg_err_q <= bus.thr_wr_i & ~thr_ok;
      if (bus.thr_wr_i && thr_ok) begin
        thr_high_q <= bus.thr_high_i;
        thr_low_q  <= bus.thr_low_i;
      end
    end
  end

  assign bus.clean_out_o = level_q;
  assign bus.rise_o      = rise_q;
  assign bus.fall_o      = fall_q;
  assign bus.evt_o       = evt_q;
  assign bus.cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_sync_filter_bank.sv
// Directed self-checking bench for sync_filter_bank.
// Inputs change 1 time unit after a rising edge; outputs sampled there too.
module tb_sync_filter_bank;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  sync_filter_bank_if #(.NUM_CH(4), .CTR_WIDTH(4)) bus ();

  sync_filter_bank #(
    .NUM_CH(4),
    .SYNC_STAGES(2),
    .CTR_WIDTH(4),
    .HIGH_THRESH(12),
    .LOW_THRESH(3)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic measure(input int ch, input logic want, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (bus.clean_out_o[ch] !== want && lat < 60);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.async_i = '0;
    bus.en_i = 1'b1;
    bus.thr_wr_i = 1'b0;
    bus.thr_high_i = '0;
    bus.thr_low_i = '0;
    bus.clr_i = '0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    tests++;
    if (bus.clean_out_o !== 4'b0000) begin
      fails++;
      $display("FAIL reset_clean: got %b expected 0000", bus.clean_out_o);
    end
    tests++;
    if (bus.rise_o !== 4'b0000 || bus.fall_o !== 4'b0000) begin
      fails++;
      $display("FAIL reset_pulses: rise %b fall %b expected 0000",
               bus.rise_o, bus.fall_o);
    end
    tests++;
    if (bus.evt_o !== 4'b0000 || bus.cfg_err_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_evt: evt %b cfg_err %b expected 0",
               bus.evt_o, bus.cfg_err_o);
    end
  endtask

  task automatic test_rise_default();
    int lat;
    bus.async_i[0] = 1'b1;
    measure(0, 1'b1, lat);
    tests++;
    if (lat != 15) begin
      fails++;
      $display("FAIL rise_latency: got %0d expected 15", lat);
    end
    tests++;
    if (bus.rise_o !== 4'b0001) begin
      fails++;
      $display("FAIL rise_pulse: got %b expected 0001", bus.rise_o);
    end
    step();
    tests++;
    if (bus.rise_o !== 4'b0000 || bus.evt_o !== 4'b0001) begin
      fails++;
      $display("FAIL rise_one_cycle: rise %b evt %b expected 0000/0001",
               bus.rise_o, bus.evt_o);
    end
  endtask

  task automatic test_fall_saturate();
    int lat;
    repeat (30) step();
    bus.async_i[0] = 1'b0;
    measure(0, 1'b0, lat);
    tests++;
    if (lat != 15) begin
      fails++;
      $display("FAIL fall_latency: got %0d expected 15", lat);
    end
    tests++;
    if (bus.fall_o !== 4'b0001 || bus.rise_o !== 4'b0000) begin
      fails++;
      $display("FAIL fall_pulse: fall %b rise %b expected 0001/0000",
               bus.fall_o, bus.rise_o);
    end
    repeat (20) step();
    tests++;
    if (bus.clean_out_o[0] !== 1'b0) begin
      fails++;
      $display("FAIL floor_no_wrap: got %b expected 0", bus.clean_out_o[0]);
    end
    bus.async_i[0] = 1'b1;
    measure(0, 1'b1, lat);
    tests++;
    if (lat != 15) begin
      fails++;
      $display("FAIL rerise_latency: got %0d expected 15", lat);
    end
  endtask

  task automatic test_glitch();
    int   widths [4] = '{1, 2, 5, 11};
    logic seen;
    int   lat;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.async_i[1] = 1'b1;
      repeat (widths[i]) begin
        step();
        seen |= bus.clean_out_o[1] | bus.rise_o[1];
      end
      bus.async_i[1] = 1'b0;
      repeat (12) begin
        step();
        seen |= bus.clean_out_o[1] | bus.rise_o[1];
      end
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL glitch_reject: got %b expected 0", seen);
    end
    repeat (20) step();
    bus.async_i[1] = 1'b1;
    repeat (11) step();
    bus.async_i[1] = 1'b0;
    step();
    bus.async_i[1] = 1'b1;
    measure(1, 1'b1, lat);
    tests++;
    if (lat != 5 || bus.rise_o[1] !== 1'b1) begin
      fails++;
      $display("FAIL glitch_train: lat %0d rise %b expected 5/1",
               lat, bus.rise_o[1]);
    end
    bus.async_i[1] = 1'b0;
    repeat (30) step();
  endtask

  task automatic test_threshold();
    int lat;
    bus.thr_wr_i = 1'b1;
    bus.thr_high_i = 4'd6;
    bus.thr_low_i = 4'd5;
    step();
    bus.thr_wr_i = 1'b0;
    tests++;
    if (bus.cfg_err_o !== 1'b0) begin
      fails++;
      $display("FAIL thr_accept: cfg_err %b expected 0", bus.cfg_err_o);
    end
    bus.async_i[3] = 1'b1;
    measure(3, 1'b1, lat);
    tests++;
    if (lat != 9) begin
      fails++;
      $display("FAIL thr_latency: got %0d expected 9", lat);
    end
    bus.async_i[3] = 1'b0;
    repeat (30) step();
    bus.thr_wr_i = 1'b1;
    bus.thr_high_i = 4'd4;
    bus.thr_low_i = 4'd4;
    step();
    bus.thr_wr_i = 1'b0;
    tests++;
    if (bus.cfg_err_o !== 1'b1) begin
      fails++;
      $display("FAIL thr_reject_eq: cfg_err %b expected 1", bus.cfg_err_o);
    end
    step();
    tests++;
    if (bus.cfg_err_o !== 1'b0) begin
      fails++;
      $display("FAIL thr_err_width: cfg_err %b expected 0", bus.cfg_err_o);
    end
    bus.thr_wr_i = 1'b1;
    bus.thr_high_i = 4'd2;
    bus.thr_low_i = 4'd7;
    step();
    bus.thr_wr_i = 1'b0;
    tests++;
    if (bus.cfg_err_o !== 1'b1) begin
      fails++;
      $display("FAIL thr_reject_inv: cfg_err %b expected 1", bus.cfg_err_o);
    end
    bus.async_i[3] = 1'b1;
    measure(3, 1'b1, lat);
    tests++;
    if (lat != 9) begin
      fails++;
      $display("FAIL thr_latency_kept: got %0d expected 9", lat);
    end
    bus.thr_wr_i = 1'b1;
    bus.thr_high_i = 4'd12;
    bus.thr_low_i = 4'd3;
    step();
    bus.thr_wr_i = 1'b0;
    bus.async_i[3] = 1'b0;
    repeat (30) step();
  endtask

  task automatic test_enable_sticky();
    int         lat;
    logic       pulsed;
    logic [3:0] held;
    bus.async_i[2] = 1'b1;
    repeat (10) step();
    bus.en_i = 1'b0;
    held = bus.clean_out_o;
    pulsed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.async_i[2] = ~bus.async_i[2];
      step();
      pulsed |= (|bus.rise_o) | (|bus.fall_o) | (bus.clean_out_o != held);
    end
    tests++;
    if (pulsed !== 1'b0) begin
      fails++;
      $display("FAIL freeze: activity %b expected 0", pulsed);
    end
    bus.clr_i[0] = 1'b1;
    step();
    bus.clr_i[0] = 1'b0;
    tests++;
    if (bus.evt_o[0] !== 1'b0) begin
      fails++;
      $display("FAIL clr_while_off: evt0 %b expected 0", bus.evt_o[0]);
    end
    bus.async_i[2] = 1'b1;
    bus.en_i = 1'b1;
    measure(2, 1'b1, lat);
    tests++;
    if (lat != 5 || bus.rise_o[2] !== 1'b1) begin
      fails++;
      $display("FAIL resume: lat %0d rise %b expected 5/1", lat, bus.rise_o[2]);
    end
    bus.clr_i[2] = 1'b1;
    step();
    tests++;
    if (bus.evt_o[2] !== 1'b1) begin
      fails++;
      $display("FAIL set_wins: evt2 %b expected 1", bus.evt_o[2]);
    end
    step();
    bus.clr_i[2] = 1'b0;
    tests++;
    if (bus.evt_o[2] !== 1'b0) begin
      fails++;
      $display("FAIL w1c: evt2 %b expected 0", bus.evt_o[2]);
    end
  endtask

  task automatic test_multi_reset();
    int off [4] = '{0, 2, 5, 7};
    int rt  [4];
    int nr  [4];
    int lat;
    bus.async_i = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int ch = 0; ch < 4; ch++) begin
      rt[ch] = -1;
      nr[ch] = 0;
    end
    for (int s = 0; s < 40; s++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (s == off[ch]) bus.async_i[ch] = 1'b1;
      end
      step();
      for (int ch = 0; ch < 4; ch++) begin
        if (bus.rise_o[ch]) nr[ch]++;
        if (bus.clean_out_o[ch] && rt[ch] < 0) rt[ch] = s + 1;
      end
    end
    for (int ch = 0; ch < 4; ch++) begin
      tests++;
      if (rt[ch] != off[ch] + 15 || nr[ch] != 1) begin
        fails++;
        $display("FAIL multi_ch%0d: rise at %0d count %0d expected %0d/1",
                 ch, rt[ch], nr[ch], off[ch] + 15);
      end
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.clean_out_o !== 4'b0000 || bus.evt_o !== 4'b0000) begin
      fails++;
      $display("FAIL async_reset: clean %b evt %b expected 0000",
               bus.clean_out_o, bus.evt_o);
    end
    #1;
    rst_n = 1'b1;
    measure(0, 1'b1, lat);
    tests++;
    if (lat != 15 || bus.rise_o !== 4'b1111) begin
      fails++;
      $display("FAIL post_reset: lat %0d rise %b expected 15/1111",
               lat, bus.rise_o);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_rise_default();
    test_fall_saturate();
    test_glitch();
    test_threshold();
    test_enable_sticky();
    test_multi_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_filter_bank.md
Name: sync_filter_bank

Overview:
Multi-channel successor to the single-input sync-and-filter block. Each of NUM_CH asynchronous inputs passes through a synchronizer of configurable depth and a saturating up/down counter with hysteresis. The block emits a clean level, single-cycle rise/fall pulses and write-one-to-clear sticky event flags per channel. Thresholds are runtime-programmable through a validated write port, and a global enable freezes filtering. It sits between board-level inputs (buttons, comparator outputs, range straps) and the voltmeter control logic.

Parameters:
NUM_CH, 4, number of independent channels
SYNC_STAGES, 2, synchronizer flops per channel (legal range 2..4)
CTR_WIDTH, 4, filter counter width; CTR_MAX = 2^CTR_WIDTH-1
HIGH_THRESH, 12, reset value of the high threshold
LOW_THRESH, 3, reset value of the low threshold

Ports:
clk_i  in  1  single system clock
rst_n_i  in  1  reset, asynchronous assert, active-low
async_i  in  NUM_CH  raw asynchronous inputs
en_i  in  1  1 = filter runs; 0 = counters, levels and sync chain frozen
thr_wr_i  in  1  one-cycle threshold write strobe
thr_high_i  in  CTR_WIDTH  proposed high threshold
thr_low_i  in  CTR_WIDTH  proposed low threshold
cfg_err_o  out  1  one-cycle pulse when a threshold write is rejected
clr_i  in  NUM_CH  write-one-to-clear for evt_o bits
clean_out_o  out  NUM_CH  filtered level per channel
rise_o  out  NUM_CH  one-cycle pulse on a clean_out_o 0->1 transition
fall_o  out  NUM_CH  one-cycle pulse on a clean_out_o 1->0 transition
evt_o  out  NUM_CH  sticky flag, set on any rise or fall

Behaviour:
- Reset (async, rst_n_i=0): all sync flops, counters, clean_out_o, rise_o, fall_o, evt_o and cfg_err_o are 0. Active thresholds load HIGH_THRESH and LOW_THRESH.
- Elaboration check: HIGH_THRESH > LOW_THRESH, HIGH_THRESH <= CTR_MAX, and SYNC_STAGES in 2..4. Any violation is a fatal error.
- Synchronizer: shift register per channel; sync_q is the last stage. There is no combinational path from async_i.
- Counter per channel, with en_i=1:
  - sync_q=1 and ctr<CTR_MAX: ctr+1.
  - sync_q=0 and ctr>0: ctr-1.
  - Otherwise hold. Counter saturates at CTR_MAX and floors at 0, with no wrap.
- Level register, evaluated on ctr_q (the current counter value):
  - ctr_q >= thr_high: next level 1.
  - ctr_q <= thr_low: next level 0.
  - Otherwise hold.
- Latency: counting from the edge that first samples a stable 1, with ctr=0 and defaults, clean_out_o rises after edge SYNC_STAGES+thr_high+1 (15 with defaults). From saturation (ctr=15) with a stable 0, clean_out_o falls after edge SYNC_STAGES+(CTR_MAX-thr_low)+1 (15 with defaults).
- rise_o/fall_o: registered, asserted in the same cycle clean_out_o first shows the new value, one cycle wide. They are never both high on one channel.
- evt_o[ch]: set when rise_o[ch] or fall_o[ch] is 1, cleared by clr_i[ch]=1. If set and clear happen in the same cycle, set wins.
- en_i=0:
  - Sync chain, counters and levels hold.
  - rise_o/fall_o are 0.
  - evt_o still honours clr_i.
  - On re-enable, filtering resumes from the held state. The stale sync value is used for one cycle.
- Threshold write when thr_wr_i=1:
  - Accepted if thr_high_i > thr_low_i. Active thresholds update at that edge and are used from the next cycle. Counters and levels are not disturbed.
  - Rejected otherwise: thresholds unchanged, cfg_err_o=1 for exactly one cycle.
  - A write during en_i=0 is still processed.
- Channels are fully independent and share only the thresholds and en_i.
- Reset mid-operation: all state clears immediately. Any pending pulse is lost and evt_o clears.

Test Plan:
- Reset/defaults: hold reset, release with async_i=0 -> all outputs 0. Drive ch0=1 -> clean_out_o[0]=1 and rise_o[0]=1 after exactly 15 edges; rise_o is 1 for one cycle only; evt_o[0]=1.
- Saturate and fall: keep ch0=1 for 30 cycles, then 0 -> fall_o[0] after 15 edges. Counter floors at 0 with no wrap (a 1 later takes the full 15 cycles again).
- Glitch rejection: pulses of 1, 2, 5 and 11 cycles high separated by 12 cycles low on ch1 -> clean_out_o[1] stays 0, no rise_o. An 11-high/1-low/1-high train asserts the level (ctr reaches 12).
- Threshold write: write high=6, low=5 -> accepted, rise latency becomes 9 edges. Write high=4, low=4 and high=2, low=7 -> cfg_err_o pulses one cycle each, latency stays 9.
- Enable freeze and sticky: with ch2 at ctr=8, drop en_i for 20 cycles while toggling async_i -> no level change and no pulses; restore and complete the rise. Assert clr_i[2] in the same cycle as rise_o[2] -> evt_o[2] stays 1; clear one cycle later -> 0.
- Multi-channel and async reset: drive 4 channels with staggered edges -> independent, correct latencies. Pulse rst_n_i low mid-count between clock edges -> immediate clear, and the next rise takes the full 15 cycles.
